// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider beside the EX stage
// Optional abort input annul_i is enabled by defining EX_DIV_ANNUL_EN.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
`ifdef EX_DIV_ANNUL_EN
  input  logic                annul_i,
`endif
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quot;
  logic                neg_rem;
  logic                annul;
  logic                div_zero;
  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quot_raw;
  logic [DATA_W-1:0]   rem_raw;
  logic [DATA_W-1:0]   quot_fin;
  logic [DATA_W-1:0]   rem_fin;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

`ifdef EX_DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = 1'b0;
`endif

  assign div_zero = (opdata2_i == '0);
  assign op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs  = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs  = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // Dividend sits one bit up so each step's trial window is work[2W-1:W]
  // after the implicit shift; the remainder ends in the top W bits.
  assign diff     = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  assign quot_raw = work[DATA_W-1:0];
  assign rem_raw  = work[2*DATA_W:DATA_W+1];
  assign quot_fin = neg_quot ? (~quot_raw + 1'b1) : quot_raw;
  assign rem_fin  = neg_rem  ? (~rem_raw + 1'b1)  : rem_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = S_FREE;
    end else begin
      case (state)
        S_FREE: begin
          if (start_i) begin
            state_nxt = div_zero ? S_BYZERO : S_ON;
          end
        end
        // Two cycles in BYZERO so the zero result lands two edges after start.
        S_BYZERO: begin
          if (cnt == CNT_ONE) begin
            state_nxt = S_END;
          end
        end
        S_ON: begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            state_nxt = S_FREE;
          end
        end
        default: state_nxt = S_FREE;
      endcase
    end
  end

  always_comb begin
    result_nxt = result_o;
    ready_nxt  = ready_o;
    if (annul) begin
      result_nxt = '0;
      ready_nxt  = 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
        S_BYZERO: begin
          if (cnt == CNT_ONE) begin
            result_nxt = '0;
            ready_nxt  = 1'b1;
          end
        end
        S_ON: begin
          if (cnt == CNT_LAST) begin
            result_nxt = {rem_fin, quot_fin};
            ready_nxt  = 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            result_nxt = '0;
            ready_nxt  = 1'b0;
          end
        end
        default: begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (annul) begin
      cnt  <= '0;
      work <= '0;
    end else begin
      case (state)
        S_FREE: begin
          if (start_i) begin
            cnt <= '0;
            if (!div_zero) begin
              work     <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
              divisor  <= op2_abs;
              neg_quot <= op1_neg ^ op2_neg;
              neg_rem  <= op1_neg;
            end
          end
        end
        S_BYZERO: begin
          cnt  <= cnt + CNT_ONE;
          work <= '0;
        end
        S_ON: begin
          if (cnt != CNT_LAST) begin
            if (diff[DATA_W]) begin
              work <= {work[2*DATA_W-1:0], 1'b0};
            end else begin
              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
